// File: rtl/cv32e40p_ft_pkg.sv
// cv32e40p_ft_pkg: redundancy modes and per-unit default health-tracking constants
package cv32e40p_ft_pkg;
  typedef enum logic [1:0] {
    FT_TMR     = 2'd0,
    FT_DMR     = 2'd1,
    FT_SIMPLEX = 2'd2,
    FT_FAIL    = 2'd3
  } ft_mode_e;
  localparam int CDEC_INCREMENT = 4;
  localparam int CDEC_DECREMENT = 1;
  localparam int CDEC_THRESHOLD = 12;
  localparam int ALU_INCREMENT  = 4;
  localparam int ALU_DECREMENT  = 2;
  localparam int ALU_THRESHOLD  = 12;
endpackage

// File: rtl/cv32e40p_ft_redundancy_manager_if.sv
// cv32e40p_ft_redundancy_manager_if: replica data in, voted data and error flags out
interface cv32e40p_ft_redundancy_manager_if #(parameter int WIDTH = 32);
  logic                  valid_i;
  logic [2:0][WIDTH-1:0] data_i;
  logic [WIDTH-1:0]      data_o;
  logic                  valid_o;
  logic                  err_detected_o;
  logic                  err_corrected_o;
  logic                  err_uncorrectable_o;
  modport master (output valid_i, data_i, input data_o, valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o);
  modport slave (input valid_i, data_i, output data_o, valid_o, err_detected_o, err_corrected_o, err_uncorrectable_o);
endinterface

// File: rtl/cv32e40p_ft_health_counter.sv
// cv32e40p_ft_health_counter: saturating up/down error score with a sticky broken flag
module cv32e40p_ft_health_counter #(
  parameter int INCREMENT = 4,
  parameter int DECREMENT = 1,
  parameter int THRESHOLD = 12,
  parameter int COUNT_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_update,
  input  logic i_err,
  input  logic i_set,
  input  logic i_clear,
  output logic o_broken
);
  localparam logic [COUNT_BIT:0] L_MAX = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0] L_INC = (COUNT_BIT+1)'(INCREMENT);
  localparam logic [COUNT_BIT:0] L_DEC = (COUNT_BIT+1)'(DECREMENT);
  logic [COUNT_BIT-1:0] r_cnt;
  logic                 r_broken;
  logic [COUNT_BIT:0]   w_cnt, w_sum, w_next;
  logic                 w_upd;
  assign w_cnt  = {1'b0, r_cnt};
  assign w_sum  = w_cnt + L_INC;
  assign w_next = i_err ? (w_sum > L_MAX ? L_MAX : w_sum) : (w_cnt > L_DEC ? w_cnt - L_DEC : '0);
  // a broken replica no longer votes, so its score is frozen
  assign w_upd  = i_update & ~r_broken;
  assign o_broken = r_broken;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_broken <= 1'b0;
    end else begin
      r_cnt    <= i_clear ? '0 : w_upd ? w_next[COUNT_BIT-1:0] : r_cnt;
      r_broken <= i_set | (~i_clear & (r_broken | (w_upd & (32'(w_next) >= THRESHOLD))));
    end
  end
endmodule

// File: rtl/cv32e40p_ft_redundancy_manager.sv
// cv32e40p_ft_redundancy_manager: TMR voter degrading to DMR/SIMPLEX on replica health,
// with saturating corrected/uncorrectable event statistics
module cv32e40p_ft_redundancy_manager
  import cv32e40p_ft_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int INCREMENT = 4,
  parameter int DECREMENT = 1,
  parameter int THRESHOLD = 12,
  parameter int COUNT_BIT = 4,
  parameter int STAT_BIT  = 16,
  parameter bit OUT_REG   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  cv32e40p_ft_redundancy_manager_if.slave bus,
  input  logic [2:0]           set_broken_i,
  input  logic                 clear_i,
  input  logic                 stat_clear_i,
  output logic [2:0]           is_broken_o,
  output logic [1:0]           mode_o,
  output logic [STAT_BIT-1:0]  corr_cnt_o,
  output logic [STAT_BIT-1:0]  uncorr_cnt_o
);
  ft_mode_e             w_mode;
  logic [WIDTH-1:0]     w_d0, w_d1, w_d2, w_maj, w_lo, w_hi, w_data;
  logic [2:0]           w_rep_err;
  logic                 w_tmr, w_corr, w_uncorr, w_det;
  logic [STAT_BIT-1:0]  r_corr_cnt, r_uncorr_cnt;
  assign w_d0   = bus.data_i[0];
  assign w_d1   = bus.data_i[1];
  assign w_d2   = bus.data_i[2];
  // the number of broken replicas is exactly the mode encoding
  assign w_mode = ft_mode_e'(2'(is_broken_o[0]) + 2'(is_broken_o[1]) + 2'(is_broken_o[2]));
  assign mode_o = w_mode;
  assign w_tmr  = w_mode == FT_TMR;
  assign w_maj  = (w_d0 & w_d1) | (w_d0 & w_d2) | (w_d1 & w_d2);
  assign w_lo   = is_broken_o[0] ? (is_broken_o[1] ? w_d2 : w_d1) : w_d0;
  assign w_hi   = is_broken_o[2] ? w_d1 : w_d2;
  assign w_rep_err = {w_d2 != w_maj, w_d1 != w_maj, w_d0 != w_maj};
  assign w_data   = w_tmr ? w_maj : w_mode == FT_FAIL ? w_d0 : w_lo;
  assign w_corr   = bus.valid_i & w_tmr & |w_rep_err;
  assign w_uncorr = bus.valid_i & (w_mode == FT_DMR) & (w_lo != w_hi);
  assign w_det    = w_corr | w_uncorr | (bus.valid_i & (w_mode == FT_FAIL));
  for (genvar i = 0; i < 3; i++) begin : g_hc
    cv32e40p_ft_health_counter #(
      .INCREMENT(INCREMENT), .DECREMENT(DECREMENT), .THRESHOLD(THRESHOLD), .COUNT_BIT(COUNT_BIT)
    ) u_hc (
      .clk      (clk),
      .rst      (rst),
      .i_update (bus.valid_i & w_tmr),
      .i_err    (w_rep_err[i]),
      .i_set    (set_broken_i[i]),
      .i_clear  (clear_i),
      .o_broken (is_broken_o[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      r_corr_cnt   <= stat_clear_i ? '0 : (w_corr && r_corr_cnt != '1) ? r_corr_cnt + 1'b1 : r_corr_cnt;
      r_uncorr_cnt <= stat_clear_i ? '0 : (w_uncorr && r_uncorr_cnt != '1) ? r_uncorr_cnt + 1'b1 : r_uncorr_cnt;
    end
  end
  assign corr_cnt_o   = r_corr_cnt;
  assign uncorr_cnt_o = r_uncorr_cnt;
  if (OUT_REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        bus.data_o              <= '0;
        bus.valid_o             <= 1'b0;
        bus.err_detected_o      <= 1'b0;
        bus.err_corrected_o     <= 1'b0;
        bus.err_uncorrectable_o <= 1'b0;
      end else begin
        bus.data_o              <= w_data;
        bus.valid_o             <= bus.valid_i;
        bus.err_detected_o      <= w_det;
        bus.err_corrected_o     <= w_corr;
        bus.err_uncorrectable_o <= w_uncorr;
      end
    end
  end else begin : g_comb
    assign bus.data_o              = w_data;
    assign bus.valid_o             = bus.valid_i;
    assign bus.err_detected_o      = w_det;
    assign bus.err_corrected_o     = w_corr;
    assign bus.err_uncorrectable_o = w_uncorr;
  end
endmodule
